// File: rtl/npc_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU SRAM-port arbiter.
package npc_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  // Read data returned alongside an error (watchdog) completion.
  localparam int unsigned ERR_RDATA = 0;

endpackage

// File: rtl/npc_arb_pick.sv
// Combinational winner select between IFU and LSU requests.
module npc_arb_pick
  import npc_mem_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic if_valid,
  input  logic ls_valid,
  input  logic last_grant,
  output logic any_valid,
  output logic winner
);

  assign any_valid = if_valid | ls_valid;

  always_comb begin
    winner = GNT_IF;
    if (if_valid && ls_valid) begin
      // Round-robin hands the port to whoever did not get it last time.
      if (RR_EN) winner = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
      else       winner = GNT_LS;
    end else if (ls_valid) begin
      winner = GNT_LS;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares one SRAM port between IFU fetches and LSU accesses, one transaction
// at a time, with a watchdog that error-completes a hung SRAM access.
module npc_mem_arbiter
  import npc_mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter bit          RR_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  ls_valid,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  output logic                  ls_ready,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  ls_err,
  output logic                  s_valid,
  output logic [ADDR_W-1:0]     s_addr,
  output logic                  s_wen,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wmask,
  input  logic                  s_ready,
  input  logic [DATA_W-1:0]     s_rdata
);

  // The timer only has to reach TIMEOUT-1.
  localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  arb_state_t            state_reg, state_next;
  logic                  last_grant_reg, last_grant_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic                  s_valid_reg, s_valid_next;
  logic [ADDR_W-1:0]     s_addr_reg, s_addr_next;
  logic                  s_wen_reg, s_wen_next;
  logic [DATA_W-1:0]     s_wdata_reg, s_wdata_next;
  logic [DATA_W/8-1:0]   s_wmask_reg, s_wmask_next;
  logic                  if_ready_reg, if_ready_next;
  logic                  ls_ready_reg, ls_ready_next;
  logic                  if_err_reg, if_err_next;
  logic                  ls_err_reg, ls_err_next;
  logic [DATA_W-1:0]     if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]     ls_rdata_reg, ls_rdata_next;

  logic                  any_valid;
  logic                  winner;
  logic                  timeout_hit;
  logic [DATA_W-1:0]     resp_data;

  npc_arb_pick #(.RR_EN(RR_EN)) u_pick (
    .if_valid   (if_valid),
    .ls_valid   (ls_valid),
    .last_grant (last_grant_reg),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  assign timeout_hit = (TIMEOUT != 0) && (timer_reg == TIMER_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_IF;
      timer_reg      <= '0;
      s_valid_reg    <= 1'b0;
      s_addr_reg     <= '0;
      s_wen_reg      <= 1'b0;
      s_wdata_reg    <= '0;
      s_wmask_reg    <= '0;
      if_ready_reg   <= 1'b0;
      ls_ready_reg   <= 1'b0;
      if_err_reg     <= 1'b0;
      ls_err_reg     <= 1'b0;
      if_rdata_reg   <= '0;
      ls_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      timer_reg      <= timer_next;
      s_valid_reg    <= s_valid_next;
      s_addr_reg     <= s_addr_next;
      s_wen_reg      <= s_wen_next;
      s_wdata_reg    <= s_wdata_next;
      s_wmask_reg    <= s_wmask_next;
      if_ready_reg   <= if_ready_next;
      ls_ready_reg   <= ls_ready_next;
      if_err_reg     <= if_err_next;
      ls_err_reg     <= ls_err_next;
      if_rdata_reg   <= if_rdata_next;
      ls_rdata_reg   <= ls_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    timer_next      = timer_reg;
    s_valid_next    = s_valid_reg;
    s_addr_next     = s_addr_reg;
    s_wen_next      = s_wen_reg;
    s_wdata_next    = s_wdata_reg;
    s_wmask_next    = s_wmask_reg;
    if_ready_next   = 1'b0;
    ls_ready_next   = 1'b0;
    if_err_next     = 1'b0;
    ls_err_next     = 1'b0;
    if_rdata_next   = if_rdata_reg;
    ls_rdata_next   = ls_rdata_reg;
    resp_data       = s_ready ? s_rdata : DATA_W'(ERR_RDATA);

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          last_grant_next = winner;
          s_valid_next    = 1'b1;
          if (winner == GNT_LS) begin
            s_addr_next  = ls_addr;
            s_wen_next   = ls_wen;
            s_wdata_next = ls_wdata;
            s_wmask_next = ls_wmask;
            state_next   = BUSY_LS;
          end else begin
            s_addr_next  = if_addr;
            s_wen_next   = 1'b0;
            s_wdata_next = '0;
            s_wmask_next = '0;
            state_next   = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_LS: begin
        timer_next = timer_reg + TIMER_W'(1);
        // A real completion takes precedence over a coincident timeout.
        if (s_ready || timeout_hit) begin
          s_valid_next = 1'b0;
          state_next   = RESP;
          if (state_reg == BUSY_LS) begin
            ls_ready_next = 1'b1;
            ls_err_next   = ~s_ready;
            ls_rdata_next = resp_data;
          end else begin
            if_ready_next = 1'b1;
            if_err_next   = ~s_ready;
            if_rdata_next = resp_data;
          end
        end
      end
      RESP: begin
        timer_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_valid  = s_valid_reg;
  assign s_addr   = s_addr_reg;
  assign s_wen    = s_wen_reg;
  assign s_wdata  = s_wdata_reg;
  assign s_wmask  = s_wmask_reg;
  assign if_ready = if_ready_reg;
  assign ls_ready = ls_ready_reg;
  assign if_err   = if_err_reg;
  assign ls_err   = ls_err_reg;
  assign if_rdata = if_rdata_reg;
  assign ls_rdata = ls_rdata_reg;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed bench: fixed-priority instance (a) and round-robin instance (b)
// share requester stimulus; each has its own one-cycle-latency SRAM responder.
module tb_npc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, ls_valid, ls_wen;
  logic [31:0] if_addr, ls_addr, ls_wdata, sram_rdata;
  logic [3:0]  ls_wmask;
  logic        auto_ack;

  logic        if_ready_a, if_err_a, ls_ready_a, ls_err_a, s_valid_a, s_wen_a, s_ready_a;
  logic [31:0] if_rdata_a, ls_rdata_a, s_addr_a, s_wdata_a;
  logic [3:0]  s_wmask_a;
  logic        if_ready_b, if_err_b, ls_ready_b, ls_err_b, s_valid_b, s_wen_b, s_ready_b;
  logic [31:0] if_rdata_b, ls_rdata_b, s_addr_b, s_wdata_b;
  logic [3:0]  s_wmask_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic        cap_sv, cap_wen;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wmask;

  always #5 clk = ~clk;

  npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .RR_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready_a), .if_rdata(if_rdata_a), .if_err(if_err_a),
    .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_ready(ls_ready_a), .ls_rdata(ls_rdata_a), .ls_err(ls_err_a),
    .s_valid(s_valid_a), .s_addr(s_addr_a), .s_wen(s_wen_a), .s_wdata(s_wdata_a), .s_wmask(s_wmask_a),
    .s_ready(s_ready_a), .s_rdata(sram_rdata)
  );

  npc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .RR_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready_b), .if_rdata(if_rdata_b), .if_err(if_err_b),
    .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_ready(ls_ready_b), .ls_rdata(ls_rdata_b), .ls_err(ls_err_b),
    .s_valid(s_valid_b), .s_addr(s_addr_b), .s_wen(s_wen_b), .s_wdata(s_wdata_b), .s_wmask(s_wmask_b),
    .s_ready(s_ready_b), .s_rdata(sram_rdata)
  );

  // SRAM model: s_ready pulses on the cycle after s_valid rises.
  always @(posedge clk) begin
    if (rst) begin
      s_ready_a <= 1'b0;
      s_ready_b <= 1'b0;
    end else begin
      s_ready_a <= auto_ack && s_valid_a && !s_ready_a;
      s_ready_b <= auto_ack && s_valid_b && !s_ready_b;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on instance a; returns cycles from valid to ready.
  task automatic do_req(input bit is_ls, output int cyc, output int sv_cnt, output bit other_seen);
    cyc = 0;
    sv_cnt = 0;
    other_seen = 1'b0;
    if (is_ls) ls_valid = 1'b1;
    else       if_valid = 1'b1;
    while (cyc < 40) begin
      step();
      cyc++;
      if (cyc == 1) begin
        cap_sv    = s_valid_a;
        cap_addr  = s_addr_a;
        cap_wen   = s_wen_a;
        cap_wdata = s_wdata_a;
        cap_wmask = s_wmask_a;
      end
      if (s_valid_a) sv_cnt++;
      if (is_ls ? if_ready_a : ls_ready_a) other_seen = 1'b1;
      if (is_ls ? ls_ready_a : if_ready_a) break;
    end
    if_valid = 1'b0;
    ls_valid = 1'b0;
    $display("txn %s addr=%h wen=%0d cycles=%0d rdata=%h err=%0d", is_ls ? "LS" : "IF",
             cap_addr, cap_wen, cyc, is_ls ? ls_rdata_a : if_rdata_a, is_ls ? ls_err_a : if_err_a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc, sv_cnt, done;
    bit other;
    logic [3:0] ord;

    rst = 1'b1;
    if_valid = 1'b0; ls_valid = 1'b0; ls_wen = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    sram_rdata = '0; auto_ack = 1'b1;
    repeat (3) step();
    check("rst_s_valid", s_valid_a, 1'b0);
    check("rst_s_addr", s_addr_a, 32'h0);
    check("rst_readys", {if_ready_a, ls_ready_a, if_err_a, ls_err_a}, 4'h0);
    check("rst_rdata", {if_rdata_a, ls_rdata_a}, 64'h0);
    check("rst_b_s_valid", s_valid_b, 1'b0);
    rst = 1'b0;
    step();

    // Both held valid for four transactions: a always LS, b alternates LS,IF,LS,IF.
    if_addr = 32'h8000_0100; ls_addr = 32'h8000_2000; ls_wen = 1'b0;
    sram_rdata = 32'h1111_0000;
    if_valid = 1'b1; ls_valid = 1'b1;
    done = 0;
    for (int c = 0; c < 80 && done < 4; c++) begin
      step();
      if (if_ready_a || ls_ready_a) begin
        check($sformatf("hold_a_%0d", done), {if_ready_a, ls_ready_a}, 2'b01);
        check($sformatf("hold_b_%0d", done), {if_ready_b, ls_ready_b}, (done % 2 == 0) ? 2'b01 : 2'b10);
        $display("txn hold %0d a=%s b=%s", done, ls_ready_a ? "LS" : "IF", ls_ready_b ? "LS" : "IF");
        done++;
        if (done == 4) begin
          if_valid = 1'b0;
          ls_valid = 1'b0;
        end
      end
    end
    check("hold_count", done, 4);
    if_valid = 1'b0; ls_valid = 1'b0;
    repeat (2) step();

    // IFU-only read.
    if_addr = 32'h8000_0000; sram_rdata = 32'h0010_0073;
    do_req(1'b0, cyc, sv_cnt, other);
    check("if_lat", cyc, 3);
    check("if_s_valid", cap_sv, 1'b1);
    check("if_s_addr", cap_addr, 32'h8000_0000);
    check("if_s_wen_wmask", {cap_wen, cap_wmask}, 5'h0);
    check("if_rdata", if_rdata_a, 32'h0010_0073);
    check("if_err", if_err_a, 1'b0);
    step();
    check("if_pulse_once", if_ready_a, 1'b0);
    check("if_rdata_hold", if_rdata_a, 32'h0010_0073);

    // LSU store.
    ls_addr = 32'h8000_1000; ls_wen = 1'b1; ls_wdata = 32'hDEAD_BEEF; ls_wmask = 4'hF;
    sram_rdata = 32'h1234_5678;
    do_req(1'b1, cyc, sv_cnt, other);
    check("st_lat", cyc, 3);
    check("st_s_addr", cap_addr, 32'h8000_1000);
    check("st_s_wen", cap_wen, 1'b1);
    check("st_s_wdata", cap_wdata, 32'hDEAD_BEEF);
    check("st_s_wmask", cap_wmask, 4'hF);
    check("st_no_if_ready", other, 1'b0);
    check("st_ls_rdata", ls_rdata_a, 32'h1234_5678);
    step();
    check("st_pulse_once", ls_ready_a, 1'b0);

    // Simultaneous single requests on a: LS first, then IF.
    ls_wen = 1'b0; ls_wmask = 4'h0; ls_addr = 32'h8000_3000; if_addr = 32'h8000_0004;
    if_valid = 1'b1; ls_valid = 1'b1;
    ord = '0; done = 0;
    for (int c = 0; c < 40 && done < 2; c++) begin
      step();
      if (if_ready_a || ls_ready_a) begin
        ord = {ord[1:0], ls_ready_a, if_ready_a};
        $display("txn simul %0d %s", done, ls_ready_a ? "LS" : "IF");
        if (ls_ready_a) ls_valid = 1'b0;
        if (if_ready_a) if_valid = 1'b0;
        done++;
      end
    end
    check("simul_order", ord, 4'b1001);
    if_valid = 1'b0; ls_valid = 1'b0;
    step();

    // Watchdog: no s_ready at all.
    auto_ack = 1'b0; ls_addr = 32'h8000_4000;
    do_req(1'b1, cyc, sv_cnt, other);
    check("to_s_valid_cycles", sv_cnt, 4);
    check("to_lat", cyc, 5);
    check("to_err", ls_err_a, 1'b1);
    check("to_rdata", ls_rdata_a, 32'h0);
    step();
    check("to_err_clear", {ls_ready_a, ls_err_a}, 2'b00);
    auto_ack = 1'b1;
    repeat (4) step();

    ls_addr = 32'h8000_5000; sram_rdata = 32'hCAFE_F00D;
    do_req(1'b1, cyc, sv_cnt, other);
    check("post_to_lat", cyc, 3);
    check("post_to_rdata", ls_rdata_a, 32'hCAFE_F00D);
    check("post_to_err", ls_err_a, 1'b0);
    step();

    // Reset while BUSY_IF.
    auto_ack = 1'b0; if_addr = 32'h8000_0008; if_valid = 1'b1;
    step();
    check("busy_s_valid", s_valid_a, 1'b1);
    rst = 1'b1;
    step();
    check("mid_rst_s_valid", s_valid_a, 1'b0);
    check("mid_rst_if_ready", if_ready_a, 1'b0);
    if_valid = 1'b0; rst = 1'b0; auto_ack = 1'b1;
    step();
    check("post_rst_idle", {s_valid_a, if_ready_a}, 2'b00);
    sram_rdata = 32'h0BAD_F00D;
    do_req(1'b0, cyc, sv_cnt, other);
    check("post_rst_lat", cyc, 3);
    check("post_rst_addr", cap_addr, 32'h8000_0008);
    check("post_rst_rdata", if_rdata_a, 32'h0BAD_F00D);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
